alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the datapath ALU. Single-cycle ADD/SUB/ADC/SBC/AND/OR/XOR

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_rot_unit.sv | 55 +++++
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and flag bit positions for the sequential ALU.
// Flag positions N and V are only meaningful when ALU_FLAGS_EXT_EN is defined.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ROT  = 2'b01
    } state_t;

    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_rot_unit.sv
// WIDTH+1 bit rotate-through-carry ring with a down-counter; one right rotation per edge.
// 'last' flags the edge that performs the final step; dout/cout present that step's result.
module alu_rot_unit #(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             cin,
    input  logic [AW-1:0]    amt,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] dout,
    output logic             cout
);

    logic [WIDTH-1:0] data_reg;
    logic             c_reg;
    logic [AW-1:0]    cnt_reg;
    logic [WIDTH-1:0] rot_data;
    logic             rot_c;

    // Ring {c, data} shifts right: carry enters the MSB, data LSB becomes the carry.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_ring
            assign rot_data[gi] = data_reg[gi+1];
        end
    endgenerate
    assign rot_data[WIDTH-1] = c_reg;
    assign rot_c             = data_reg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            c_reg    <= 1'b0;
            cnt_reg  <= '0;
        end else if (start) begin
            data_reg <= din;
            c_reg    <= cin;
            cnt_reg  <= amt;
        end else if (cnt_reg != '0) begin
            data_reg <= rot_data;
            c_reg    <= rot_c;
            cnt_reg  <= cnt_reg - 1'b1;
        end
    end

    assign busy = (cnt_reg != '0);
    assign last = (cnt_reg == AW'(1));
    assign dout = rot_data;
    assign cout = rot_c;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic, multi-cycle rotate-through-carry, registered flags.
// Define ALU_FLAGS_EXT_EN to drive the negative (n) and signed-overflow (v) flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       aluop,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluout,
    output logic             c,
    output logic             z,
    output logic             n,
    output logic             v
);

    localparam int AW = $clog2(WIDTH + 1);

    state_t               state_reg, state_next;
    logic                 out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]     aluout_reg, aluout_next;
    logic [NUM_FLAGS-1:0] flags_reg, flags_next;

    logic [AW-1:0]    amt;
    logic             accept;
    logic             rot_start;
    logic             rot_busy;
    logic             rot_last;
    logic [WIDTH-1:0] rot_dout;
    logic             rot_cout;

    logic [WIDTH:0]   wide_res;
    logic [WIDTH-1:0] op_res;
    logic             op_c;
    logic             op_arith;
    logic             op_subt;
    logic             op_v;

    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_c;
    logic             load_v;

    assign amt       = in2[AW-1:0];
    assign in_ready  = (state_reg == S_IDLE) & (~out_valid_reg | out_ready);
    assign accept    = in_valid & in_ready;
    assign rot_start = accept & (aluop == OP_ROR) & (amt != '0);

    alu_rot_unit #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_rot (
        .clk   (clk),
        .rst_n (rst_n),
        .start (rot_start),
        .din   (in1),
        .cin   (cin),
        .amt   (amt),
        .busy  (rot_busy),
        .last  (rot_last),
        .dout  (rot_dout),
        .cout  (rot_cout)
    );

    // Arithmetic is done zero-extended in WIDTH+1 bits so bit WIDTH is carry/borrow.
    always_comb begin
        wide_res = '0;
        op_res   = in1;
        op_c     = flags_reg[FLAG_C];
        op_arith = 1'b0;
        op_subt  = 1'b0;
        op_v     = 1'b0;
        case (aluop)
            OP_ADD: begin
                wide_res = {1'b0, in1} + {1'b0, in2};
                op_arith = 1'b1;
            end
            OP_ADC: begin
                wide_res = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, cin};
                op_arith = 1'b1;
            end
            OP_SUB: begin
                wide_res = {1'b0, in1} - {1'b0, in2};
                op_arith = 1'b1;
                op_subt  = 1'b1;
            end
            OP_SBC: begin
                wide_res = {1'b0, in1} - {1'b0, in2} - {{WIDTH{1'b0}}, cin};
                op_arith = 1'b1;
                op_subt  = 1'b1;
            end
            OP_AND: op_res = in1 & in2;
            OP_OR:  op_res = in1 | in2;
            OP_XOR: op_res = in1 ^ in2;
            // Zero-amount rotate is a pass-through that still loads the carry.
            OP_ROR: begin
                op_res = in1;
                op_c   = cin;
            end
            default: op_res = in1;
        endcase
        if (op_arith) begin
            op_res = wide_res[WIDTH-1:0];
            op_c   = wide_res[WIDTH];
            if (op_subt)
                op_v = (in1[WIDTH-1] != in2[WIDTH-1]) && (op_res[WIDTH-1] != in1[WIDTH-1]);
            else
                op_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (op_res[WIDTH-1] != in1[WIDTH-1]);
        end
    end

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg & ~out_ready;
        aluout_next    = aluout_reg;
        flags_next     = flags_reg;
        load           = 1'b0;
        load_res       = op_res;
        load_c         = op_c;
        load_v         = op_v;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (rot_start)
                        state_next = S_ROT;
                    else
                        load = 1'b1;
                end
            end
            S_ROT: begin
                if (rot_last) begin
                    load       = 1'b1;
                    load_res   = rot_dout;
                    load_c     = rot_cout;
                    load_v     = 1'b0;
                    state_next = S_IDLE;
                end else if (!rot_busy) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (load) begin
            out_valid_next     = 1'b1;
            aluout_next        = load_res;
            flags_next[FLAG_C] = load_c;
            flags_next[FLAG_Z] = (load_res == '0);
`ifdef ALU_FLAGS_EXT_EN
            flags_next[FLAG_N] = load_res[WIDTH-1];
            flags_next[FLAG_V] = load_v;
`endif
        end
`ifndef ALU_FLAGS_EXT_EN
        // Without the extension these bits stay constant zero and fold away.
        flags_next[FLAG_N] = 1'b0;
        flags_next[FLAG_V] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            aluout_reg    <= '0;
            flags_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            aluout_reg    <= aluout_next;
            flags_reg     <= flags_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign aluout    = aluout_reg;
    assign c         = flags_reg[FLAG_C];
    assign z         = flags_reg[FLAG_Z];
    assign n         = flags_reg[FLAG_N];
    assign v         = flags_reg[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): directed vectors queue expected results, a monitor checks them.
// Expected n/v follow ALU_FLAGS_EXT_EN when the bench is built with it.
module tb_alu_seq;

    localparam int W = 16;
`ifdef ALU_FLAGS_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    localparam logic [2:0] T_ADD = 3'b000;
    localparam logic [2:0] T_SUB = 3'b001;
    localparam logic [2:0] T_ADC = 3'b010;
    localparam logic [2:0] T_SBC = 3'b011;
    localparam logic [2:0] T_AND = 3'b100;
    localparam logic [2:0] T_OR  = 3'b101;
    localparam logic [2:0] T_XOR = 3'b110;
    localparam logic [2:0] T_ROR = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   aluop = 3'b000;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] aluout;
    logic         c, z, n, v;

    typedef struct packed {
        logic [W-1:0] d;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluout    (aluout),
        .c         (c),
        .z         (z),
        .n         (n),
        .v         (v)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_res(input logic [W-1:0] d, input logic ec, input logic ez,
                              input logic en, input logic ev);
        exp_t e;
        e.d = d;
        e.c = ec;
        e.z = ez;
        e.n = en & EXT;
        e.v = ev & EXT;
        sb.push_back(e);
    endtask

    // Presents a request and returns #1 after the edge on which it was accepted.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        int guard;
        aluop    = op;
        in1      = a;
        in2      = b;
        cin      = ci;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("issue op=%0d in1=0x%04h in2=0x%04h cin=%0d", op, a, b, ci);
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: aluout=0x%04h c=%0d z=%0d", aluout, c, z);
            end else begin
                mon_e = sb.pop_front();
                if ({aluout, c, z, n, v} !== mon_e) begin
                    n_fail++;
                    $display("FAIL result: got d=0x%04h c%0d z%0d n%0d v%0d required d=0x%04h c%0d z%0d n%0d v%0d",
                             aluout, c, z, n, v, mon_e.d, mon_e.c, mon_e.z, mon_e.n, mon_e.v);
                end else begin
                    $display("result d=0x%04h c=%0d z=%0d n=%0d v=%0d ok", aluout, c, z, n, v);
                end
            end
        end
    end

    initial begin
        int  edges;
        bit  seen_valid;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_aluout", 32'(aluout), 32'd0);
        check("rst_flags", {28'd0, c, z, n, v}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-cycle ops, back to back.
        expect_res(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(T_ADD, 16'hFFFF, 16'h0001, 1'b0);
        check("add_latency", 32'(out_valid), 32'd1);
        check("add_in_ready", 32'(in_ready), 32'd1);
        expect_res(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(T_OR, 16'h1200, 16'h0034, 1'b0);
        expect_res(16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(T_ADC, 16'h0001, 16'h0002, 1'b1);
        expect_res(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(T_SUB, 16'h0005, 16'h0005, 1'b0);
        expect_res(16'hFFFD, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(T_SBC, 16'h0003, 16'h0005, 1'b1);
        expect_res(16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(T_ADD, 16'h7FFF, 16'h0001, 1'b0);
        expect_res(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(T_AND, 16'hF0F0, 16'h0F0F, 1'b1);
        @(posedge clk);
        #1;
        check("valid_drops", 32'(out_valid), 32'd0);

        // Rotates through carry.
        expect_res(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(T_ROR, 16'h0001, 16'h0001, 1'b0);
        check("ror1_not_yet", 32'(out_valid), 32'd0);
        check("ror1_busy", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ror1_latency", 32'(out_valid), 32'd1);

        expect_res(16'hA5A5, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(T_ROR, 16'hA5A5, 16'd17, 1'b1);
        wait_valid(edges);
        check("ror17_edges", 32'(edges), 32'd17);

        expect_res(16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(T_ROR, 16'hA5A5, 16'd0, 1'b0);
        check("ror0_latency", 32'(out_valid), 32'd1);

        expect_res(16'h8123, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(T_ROR, 16'h1234, 16'd4, 1'b0);
        wait_valid(edges);
        check("ror4_edges", 32'(edges), 32'd4);
        @(posedge clk);
        #1;

        // Backpressure holds result and blocks new requests.
        out_ready = 1'b0;
        expect_res(16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(T_XOR, 16'h00FF, 16'h0F0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_aluout", 32'(aluout), 32'h0FF0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released", 32'(out_valid), 32'd0);

        // Reset in the middle of a long rotate aborts it.
        issue(T_ROR, 16'hFFFF, 16'd10, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("rot_mid_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_aluout", 32'(aluout), 32'd0);
        check("abort_flags", {28'd0, c, z, n, v}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        seen_valid = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", 32'(seen_valid), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
